sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO. Successor to the fixed 8x8 CDC FIFO for same-domain buffering.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 28 ++
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 tb/tb_sync_fifo_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH flop-based storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy tracking guards every read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost flags, sticky error flags and
// selectable standard / first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_next, rd_ptr_next, count_next;
    logic             overflow_next, underflow_next;
    logic             wr_ok, rd_ok, mem_we;
    logic [WIDTH-1:0] rd_data;

    assign rd_ok  = pop & ~empty;
    assign wr_ok  = push & (~full | rd_ok);
    assign mem_we = wr_ok & ~flush;

    always_comb begin
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count;
        overflow_next  = overflow;
        underflow_next = underflow;
        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_next = wr_ptr + 1'b1;
            if (rd_ok) rd_ptr_next = rd_ptr + 1'b1;
            count_next     = count + PW'(wr_ok) - PW'(rd_ok);
            overflow_next  = overflow  | (push & ~wr_ok);
            underflow_next = underflow | (pop  & ~rd_ok);
        end
    end

    // Flags are registered from count_next so no input reaches them combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            overflow     <= overflow_next;
            underflow    <= underflow_next;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (dataIn),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign dataOut = empty ? '0 : rd_data;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            // Flush has priority, so a pop in a flush cycle leaves the output word untouched.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    dout_q <= '0;
                end else if (rd_ok && !flush) begin
                    dout_q <= rd_data;
                end
            end
            assign dataOut = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO driven by identical stimulus.
module tb_sync_fifo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       push  = 1'b0;
    logic       pop   = 1'b0;
    logic [7:0] dataIn = '0;

    logic [7:0] dataOut, dataOut_f;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic       full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [3:0] count, count_f;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)
    ) dut_std (
        .clock(clock), .reset(reset), .flush(flush), .push(push), .dataIn(dataIn),
        .pop(pop), .dataOut(dataOut), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)
    ) dut_fwft (
        .clock(clock), .reset(reset), .flush(flush), .push(push), .dataIn(dataIn),
        .pop(pop), .dataOut(dataOut_f), .full(full_f), .empty(empty_f),
        .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_push(input logic [7:0] d);
        push = 1'b1; dataIn = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            errors++; $display("FAIL reset_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
        checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dataOut); end
        checks++; if ({count_f, empty_f, almost_empty_f, full_f, almost_full_f, overflow_f, underflow_f, dataOut_f}
                      !== {4'd0, 6'b110000, 8'h00}) begin
            errors++; $display("FAIL reset_fwft got %h/%b/%h exp 0/110000/00", count_f,
                {empty_f, almost_empty_f, full_f, almost_full_f, overflow_f, underflow_f}, dataOut_f); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b = '{8'h22, 8'h34, 8'h56};
        do_push(8'h22);
        checks++; if (dataOut_f !== 8'h22) begin errors++; $display("FAIL basic_fwft_early got %h exp 22", dataOut_f); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL basic_ae1 got %b exp 1", almost_empty); end
        do_push(8'h34);
        do_push(8'h56);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
        checks++; if ({empty, almost_empty} !== 2'b00) begin
            errors++; $display("FAIL basic_flags got %b exp 00", {empty, almost_empty}); end
        checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL basic_dout_idle got %h exp 00", dataOut); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dataOut_f !== exp_b[i]) begin
                errors++; $display("FAIL basic_fwft_%0d got %h exp %h", i, dataOut_f, exp_b[i]); end
            do_pop();
            checks++; if (dataOut !== exp_b[i]) begin
                errors++; $display("FAIL basic_pop_%0d got %h exp %h", i, dataOut, exp_b[i]); end
        end
        checks++; if ({empty, count, dataOut_f} !== {1'b1, 4'd0, 8'h00}) begin
            errors++; $display("FAIL basic_drained got %b/%0d/%h exp 1/0/00", empty, count, dataOut_f); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) begin
            do_push(8'(i));
            checks++; if (almost_full !== (i >= 6)) begin
                errors++; $display("FAIL ovf_afull_%0d got %b exp %b", i, almost_full, (i >= 6)); end
            checks++; if (full !== (i == 8)) begin
                errors++; $display("FAIL ovf_full_%0d got %b exp %b", i, full, (i == 8)); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", overflow); end
        do_push(8'hFF);
        checks++; if ({overflow, full, count} !== {2'b11, 4'd8}) begin
            errors++; $display("FAIL ovf_set got %b/%b/%0d exp 1/1/8", overflow, full, count); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d [8];
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        checks++; if (dataOut_f !== 8'h01) begin errors++; $display("FAIL fpp_fwft got %h exp 01", dataOut_f); end
        push = 1'b1; pop = 1'b1; dataIn = 8'hAA;
        tick();
        push = 1'b0; pop = 1'b0;
        checks++; if ({count, full} !== {4'd8, 1'b1}) begin
            errors++; $display("FAIL fpp_count got %0d/%b exp 8/1", count, full); end
        checks++; if (dataOut !== 8'h01) begin errors++; $display("FAIL fpp_dout got %h exp 01", dataOut); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dataOut_f !== exp_d[i]) begin
                errors++; $display("FAIL drain_fwft_%0d got %h exp %h", i, dataOut_f, exp_d[i]); end
            do_pop();
            checks++; if (dataOut !== exp_d[i]) begin
                errors++; $display("FAIL drain_%0d got %h exp %h", i, dataOut, exp_d[i]); end
        end
        checks++; if ({empty, count, overflow} !== {1'b1, 4'd0, 1'b1}) begin
            errors++; $display("FAIL drain_end got %b/%0d/%b exp 1/0/1", empty, count, overflow); end
    endtask

    task automatic test_underflow();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({overflow, dataOut} !== {1'b0, 8'hAA}) begin
            errors++; $display("FAIL udf_flush got %b/%h exp 0/aa", overflow, dataOut); end
        do_pop();
        checks++; if ({underflow, count} !== {1'b1, 4'd0}) begin
            errors++; $display("FAIL udf_set got %b/%0d exp 1/0", underflow, count); end
        checks++; if (dataOut !== 8'hAA) begin errors++; $display("FAIL udf_hold got %h exp aa", dataOut); end
        push = 1'b1; pop = 1'b1; dataIn = 8'h5A;
        tick();
        push = 1'b0; pop = 1'b0;
        checks++; if ({count, underflow, empty} !== {4'd1, 2'b10}) begin
            errors++; $display("FAIL udf_pp got %0d/%b/%b exp 1/1/0", count, underflow, empty); end
        do_pop();
        checks++; if ({dataOut, count, underflow} !== {8'h5A, 4'd0, 1'b1}) begin
            errors++; $display("FAIL udf_pop got %h/%0d/%b exp 5a/0/1", dataOut, count, underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] d, e;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            do_push(d);
        end
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            checks++; if (dataOut_f !== q[0]) begin
                errors++; $display("FAIL wrap_fwft_%0d got %h exp %h", i, dataOut_f, q[0]); end
            push = 1'b1; pop = 1'b1; dataIn = d;
            tick();
            push = 1'b0; pop = 1'b0;
            e = q.pop_front();
            q.push_back(d);
            checks++; if (dataOut !== e) begin
                errors++; $display("FAIL wrap_data_%0d got %h exp %h", i, dataOut, e); end
            checks++; if (count !== 4'd3) begin
                errors++; $display("FAIL wrap_count_%0d got %0d exp 3", i, count); end
        end
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front();
            do_pop();
            checks++; if (dataOut !== e) begin
                errors++; $display("FAIL wrap_drain_%0d got %h exp %h", i, dataOut, e); end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) do_push(8'h10 + 8'(i));
        do_push(8'hEE);
        for (int i = 0; i < 3; i++) do_pop();
        checks++; if ({count, overflow, dataOut} !== {4'd5, 1'b1, 8'h12}) begin
            errors++; $display("FAIL flush_pre got %0d/%b/%h exp 5/1/12", count, overflow, dataOut); end
        flush = 1'b1; push = 1'b1; dataIn = 8'h77;
        tick();
        flush = 1'b0; push = 1'b0;
        checks++; if ({count, empty, almost_empty, full} !== {4'd0, 3'b110}) begin
            errors++; $display("FAIL flush_state got %0d/%b/%b/%b exp 0/1/1/0", count, empty, almost_empty, full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL flush_err got %b exp 00", {overflow, underflow}); end
        checks++; if ({dataOut, dataOut_f} !== {8'h12, 8'h00}) begin
            errors++; $display("FAIL flush_dout got %h/%h exp 12/00", dataOut, dataOut_f); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) do_push(8'h40 + 8'(i));
        push = 1'b1; dataIn = 8'h99;
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({count, empty, almost_empty, full, almost_full} !== {4'd0, 4'b1100}) begin
            errors++; $display("FAIL rstmid_state got %0d/%b exp 0/1100", count, {empty, almost_empty, full, almost_full}); end
        checks++; if ({dataOut, dataOut_f, overflow, underflow} !== {16'h0000, 2'b00}) begin
            errors++; $display("FAIL rstmid_out got %h/%h/%b exp 00/00/00", dataOut, dataOut_f, {overflow, underflow}); end
        tick();
        push = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_hold got %0d exp 0", count); end
        @(negedge clock);
        reset = 1'b1;
        do_push(8'h3C);
        checks++; if ({count, dataOut_f} !== {4'd1, 8'h3C}) begin
            errors++; $display("FAIL rstmid_after got %0d/%h exp 1/3c", count, dataOut_f); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
